// File: rtl/mem7_fill_drain_ctrl_pkg.sv
// Shared definitions for the row-buffer fill/drain controllers.
// Holds the default geometry of the 28x7 pixel buffer and the controller
// state encoding so every controller and the address counter agree on them.
package mem7_fill_drain_ctrl_pkg;

  localparam int DW_DEF           = 8;
  localparam int MEM_SIZE_COL_DEF = 7;
  localparam int MEM_SIZE_ROW_DEF = 28;
  localparam int MEM_ADDR_COL_DEF = 3;
  localparam int MEM_ADDR_ROW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } buf_state_t;

endpackage

// File: rtl/mem7_fill_drain_ctrl_if.sv
// Stream handshake bundle of the fill/drain controller.
//   s_data/s_valid/s_ready       : signed pixel stream into the buffer
//   m_row_data/m_valid/m_ready   : full rows out of the buffer, column 0 in MSBs
// slave  : controller view (consumes pixels, produces rows)
// master : environment view (produces pixels, consumes rows)
interface mem7_fill_drain_ctrl_if
  import mem7_fill_drain_ctrl_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int COLS = MEM_SIZE_COL_DEF
);

  logic signed [DW-1:0]      s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic [COLS*DW-1:0]        m_row_data;
  logic                      m_valid;
  logic                      m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_row_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_row_data, m_valid
  );

endinterface

// File: rtl/raster_addr_cnt.sv
// Raster-order address counter: column runs 0..COLS-1, then wraps and the
// row advances; after the last (row, col) both wrap to 0 so the outputs
// never leave the buffer range.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear to (0,0)
//   i_en       : advance one position
//   o_row/o_col: current address
//   o_last     : current address is the final position of the frame
// With COLS=1 it degenerates to a plain row counter with o_col fixed at 0.
module raster_addr_cnt
  import mem7_fill_drain_ctrl_pkg::*;
#(
  parameter int ROWS  = MEM_SIZE_ROW_DEF,
  parameter int COLS  = MEM_SIZE_COL_DEF,
  parameter int ROW_W = MEM_ADDR_ROW_DEF,
  parameter int COL_W = MEM_ADDR_COL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_col_end;
  logic             w_row_end;

  assign w_col_end = (r_col == COL_W'(COLS-1));
  assign w_row_end = (r_row == ROW_W'(ROWS-1));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/mem7_fill_drain_ctrl.sv
// Fill/drain controller for a 28x7 pixel buffer.
// A start pulse in IDLE opens a frame: 196 pixels are written in raster
// order (FILL), then the 28 rows are read back one per cycle through a
// registered valid/ready output stage (DRAIN), and a one-cycle done pulse
// closes the frame (DONE).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : frame start pulse, honoured only in IDLE
//   bus (slave)       : s_data/s_valid/s_ready pixel in, m_row_data/m_valid/m_ready row out
//   mem_data_in, mem_wr_en, mem_in_add_col/row : buffer write port
//   mem_rd_en, mem_out_add_col/row, mem_row_data : buffer row read port (combinational data)
//   busy              : high outside IDLE
//   done              : one-cycle end-of-frame pulse
module mem7_fill_drain_ctrl
  import mem7_fill_drain_ctrl_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int MEM_SIZE_COL = MEM_SIZE_COL_DEF,
  parameter int MEM_SIZE_ROW = MEM_SIZE_ROW_DEF,
  parameter int MEM_ADDR_COL = MEM_ADDR_COL_DEF,
  parameter int MEM_ADDR_ROW = MEM_ADDR_ROW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  mem7_fill_drain_ctrl_if.slave        bus,
  output logic signed [DW-1:0]         mem_data_in,
  output logic                         mem_wr_en,
  output logic [MEM_ADDR_COL-1:0]      mem_in_add_col,
  output logic [MEM_ADDR_ROW-1:0]      mem_in_add_row,
  output logic                         mem_rd_en,
  output logic [MEM_ADDR_COL-1:0]      mem_out_add_col,
  output logic [MEM_ADDR_ROW-1:0]      mem_out_add_row,
  input  logic [MEM_SIZE_COL*DW-1:0]   mem_row_data,
  output logic                         busy,
  output logic                         done
);

  buf_state_t                  r_state;
  logic                        r_s_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_rd_done;
  logic [MEM_SIZE_COL*DW-1:0]  r_row_p1;
  logic                        r_vld_p1;

  logic w_start_ok;
  logic w_wr_en;
  logic w_rd_en;
  logic w_out_take;
  logic w_wr_last;
  logic w_rd_last;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_wr_en    = (r_state == ST_FILL) && bus.s_valid;
  assign w_out_take = r_vld_p1 && bus.m_ready;
  // A row is fetched only when the output register is empty or being
  // emptied this cycle, so a stalled row is never overwritten.
  assign w_rd_en    = (r_state == ST_DRAIN) && !r_rd_done && (!r_vld_p1 || bus.m_ready);

  raster_addr_cnt #(
    .ROWS (MEM_SIZE_ROW), .COLS (MEM_SIZE_COL),
    .ROW_W(MEM_ADDR_ROW), .COL_W(MEM_ADDR_COL)
  ) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start_ok),
    .i_en  (w_wr_en),
    .o_row (mem_in_add_row),
    .o_col (mem_in_add_col),
    .o_last(w_wr_last)
  );

  // Reads are whole rows, so the read side counts rows only (column stays 0).
  raster_addr_cnt #(
    .ROWS (MEM_SIZE_ROW), .COLS (1),
    .ROW_W(MEM_ADDR_ROW), .COL_W(MEM_ADDR_COL)
  ) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start_ok),
    .i_en  (w_rd_en),
    .o_row (mem_out_add_row),
    .o_col (mem_out_add_col),
    .o_last(w_rd_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_done <= 1'b0;
      r_row_p1  <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_rd_done <= 1'b0;
          end
        end
        ST_FILL: begin
          if (w_wr_en && w_wr_last) begin
            r_state   <= ST_DRAIN;
            r_s_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_rd_en && w_rd_last) r_rd_done <= 1'b1;
          // Once every row is issued, the row held in the output stage is
          // the last one; its acceptance ends the frame.
          if (r_rd_done && w_out_take) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase

      // output stage p1: one-cycle read latency
      if (w_rd_en) begin
        r_row_p1 <= mem_row_data;
        r_vld_p1 <= 1'b1;
      end else if (w_out_take) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign mem_wr_en      = w_wr_en;
  assign mem_data_in    = (r_state == ST_FILL) ? bus.s_data : '0;
  assign mem_rd_en      = w_rd_en;
  assign bus.s_ready    = r_s_ready;
  assign bus.m_row_data = r_row_p1;
  assign bus.m_valid    = r_vld_p1;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_mem7_fill_drain_ctrl.sv
module tb_mem7_fill_drain_ctrl;

  localparam int DW   = 8;
  localparam int NC   = 7;
  localparam int NR   = 28;
  localparam int NPIX = NR * NC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  mem7_fill_drain_ctrl_if #(.DW(DW), .COLS(NC)) bus ();

  logic signed [DW-1:0] mem_data_in;
  logic                 mem_wr_en;
  logic [2:0]           mem_in_add_col;
  logic [4:0]           mem_in_add_row;
  logic                 mem_rd_en;
  logic [2:0]           mem_out_add_col;
  logic [4:0]           mem_out_add_row;
  logic [NC*DW-1:0]     mem_row_data;
  logic                 busy;
  logic                 done;

  mem7_fill_drain_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bus            (bus),
    .mem_data_in    (mem_data_in),
    .mem_wr_en      (mem_wr_en),
    .mem_in_add_col (mem_in_add_col),
    .mem_in_add_row (mem_in_add_row),
    .mem_rd_en      (mem_rd_en),
    .mem_out_add_col(mem_out_add_col),
    .mem_out_add_row(mem_out_add_row),
    .mem_row_data   (mem_row_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Behavioural buffer: synchronous write, combinational row read.
  logic [DW-1:0] mem [NR][NC];
  always @(posedge clk) begin
    if (mem_wr_en && mem_in_add_row < NR && mem_in_add_col < NC)
      mem[mem_in_add_row][mem_in_add_col] <= mem_data_in;
  end
  always_comb begin
    mem_row_data = '0;
    if (mem_out_add_row < NR)
      for (int c = 0; c < NC; c++)
        mem_row_data[(NC-1-c)*DW +: DW] = mem[mem_out_add_row][c];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0] r;
    logic [2:0] c;
    logic [7:0] d;
  } wr_t;

  wr_t              wq[$];
  logic [NC*DW-1:0] rq[$];

  int  rows_acc = 0;
  int  rd_count = 0;
  int  last_acc_cyc = 0;
  bit  exp_done_next = 0, exp_done_low = 0, prev_hold = 0, pend_rd = 0;
  logic [NC*DW-1:0] prev_row;
  int  rdy_mode = 0;
  bit  stalled = 0;
  int  stall_left = 0;

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rows_acc = 0; rd_count = 0;
        exp_done_next = 0; exp_done_low = 0; prev_hold = 0; pend_rd = 0;
      end else begin
        if (mem_wr_en || mem_rd_en) chk("wr_rd_exclusive", 64'(mem_wr_en & mem_rd_en), 64'd0);
        if (mem_wr_en) begin
          if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
          else begin
            e = wq.pop_front();
            chk("write", 64'({mem_in_add_row, mem_in_add_col, mem_data_in}), 64'(e));
          end
        end
        if (pend_rd) chk("read_latency_valid", 64'(bus.m_valid), 64'd1);
        pend_rd = mem_rd_en;
        if (mem_rd_en) begin
          chk("rd_addr", 64'({mem_out_add_row, mem_out_add_col}), 64'({rd_count[4:0], 3'b000}));
          rd_count = (rd_count + 1) % NR;
        end
        if (prev_hold) begin
          chk("stall_valid", 64'(bus.m_valid), 64'd1);
          chk("stall_data", 64'(bus.m_row_data), 64'(prev_row));
        end
        if (bus.m_valid && !bus.m_ready) chk("stall_no_read", 64'(mem_rd_en), 64'd0);
        prev_hold = bus.m_valid && !bus.m_ready;
        prev_row  = bus.m_row_data;
        if (exp_done_low) begin
          chk("done_width", 64'(done), 64'd0);
          chk("busy_after_done", 64'(busy), 64'd0);
          exp_done_low = 0;
        end else if (exp_done_next) begin
          chk("done_pulse", 64'(done), 64'd1);
          exp_done_next = 0;
          exp_done_low  = 1;
        end else if (done) begin
          chk("spurious_done", 64'(done), 64'd0);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (rdy_mode == 0 && rows_acc > 0) chk("back_to_back", 64'(cyc), 64'(last_acc_cyc + 1));
          last_acc_cyc = cyc;
          if (rq.size() == 0) chk("unexpected_row", 64'd1, 64'd0);
          else chk($sformatf("row%0d", rows_acc), 64'(bus.m_row_data), 64'(rq.pop_front()));
          rows_acc++;
          if (rows_acc == NR) begin
            rows_acc = 0;
            exp_done_next = 1;
          end
        end
      end
    end
  end

  // Downstream ready: always, random, or a 5-cycle stall while row 10 is presented.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (stall_left > 0) begin
            bus.m_ready = 1'b0;
            stall_left--;
          end else if (bus.m_valid && rows_acc == 10 && !stalled) begin
            stalled = 1;
            stall_left = 4;
            bus.m_ready = 1'b0;
          end else begin
            bus.m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   64'(bus.s_ready), 64'd0);
    chk({tag, "_wr_en"},     64'(mem_wr_en), 64'd0);
    chk({tag, "_rd_en"},     64'(mem_rd_en), 64'd0);
    chk({tag, "_addrs"},     64'({mem_in_add_row, mem_in_add_col, mem_out_add_row, mem_out_add_col}), 64'd0);
    chk({tag, "_data_in"},   64'(mem_data_in), 64'd0);
    chk({tag, "_row_data"},  64'(bus.m_row_data), 64'd0);
    chk({tag, "_m_valid"},   64'(bus.m_valid), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
  endtask

  // Reset held for one edge with s_valid still high and s_data non-zero.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = 8'sh5A;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs(tag);
    wq.delete();
    rq.delete();
    bus.s_valid = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // One frame: pat 0 = ramp 0..195, 1 = random, 2 = random with -128 sprinkled.
  task automatic run_frame(input int pat, input bit toggle, input int abort_px,
                           input int abort_row, input bit idle_gap);
    logic signed [DW-1:0] px[NPIX];
    logic [NC*DW-1:0] rowv;
    int n;
    for (int i = 0; i < NPIX; i++) begin
      case (pat)
        0:       px[i] = 8'(i);
        1:       px[i] = 8'($urandom);
        default: px[i] = (i % 13 == 0) ? -8'sd128 : 8'($urandom);
      endcase
    end
    for (int r = 0; r < NR; r++) begin
      rowv = '0;
      for (int c = 0; c < NC; c++) rowv = {rowv[(NC-1)*DW-1:0], px[r*NC+c]};
      rq.push_back(rowv);
    end
    stalled = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fill_s_ready", 64'(bus.s_ready), 64'd1);
    chk("fill_busy", 64'(busy), 64'd1);
    for (int i = 0; i < NPIX; i++) begin
      if (toggle) begin
        bus.s_valid = 1'b0;
        bus.s_data = 8'($urandom);
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data = px[i];
      wq.push_back('{r: 5'(i / NC), c: 3'(i % NC), d: px[i]});
      if (i == 60) start = 1'b1;
      if (i == abort_px) begin
        do_reset("rst_fill");
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.s_valid = 1'b0;
    chk("s_ready_after_last", 64'(bus.s_ready), 64'd0);
    n = 0;
    while (!done && n < 3000) begin
      if (abort_row >= 0 && rows_acc == abort_row) begin
        start = 1'b0;
        do_reset("rst_drain");
        return;
      end
      start = (n == 3);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("frame_done", 64'(done), 64'd1);
    if (!done) begin
      do_reset("rst_timeout");
      return;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
    chk("writes_all_seen", 64'(wq.size()), 64'd0);
    chk("rows_all_seen", 64'(rq.size()), 64'd0);
    if (idle_gap) begin
      @(posedge clk); #1;
      chk("idle_hold_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("por");
    @(posedge clk); #1;

    rdy_mode = 0; run_frame(0, 0, -1, -1, 1);
    rdy_mode = 0; run_frame(1, 1, -1, -1, 0);
    rdy_mode = 2; run_frame(1, 0, -1, -1, 1);
    rdy_mode = 0; run_frame(1, 0, 100, -1, 1);
    rdy_mode = 0; run_frame(1, 0, -1, -1, 1);
    rdy_mode = 0; run_frame(1, 0, -1, 14, 1);
    rdy_mode = 1; run_frame(2, 1, -1, -1, 1);
    rdy_mode = 0; run_frame(2, 0, -1, -1, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
